cu_stream_loader: RTL
=====================

Name: cu_stream_loader

Overview:
- Writer side of the computing unit's FIFO write interfaces (activation, weight and offset ports, each a wr_en/full pair).
- Fetches vectors from a synchronous-read scratchpad (1-cycle read latency) and pushes them in a fixed job order: weights, weight-update request, offsets, activations.
- Started by the sequencer with a job descriptor; reports busy and issues a done pulse.

Parameters:
- LANES, 16, elements per vector (equals the systolic activation/weight counts).
- DATA_W, `DATA_TYPE_SIZE, bits per element.
- ADDR_W, 12, scratchpad word-address width.
- LEN_W, 10, width of the activation-length field.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  job start; sampled in IDLE only.
- w_base_i  in  ADDR_W  first weight vector address.
- off_base_i  in  ADDR_W  offset vector address.
- act_base_i  in  ADDR_W  first activation vector address.
- act_len_i  in  LEN_W  number of activation vectors; 0 is legal.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle pulse at job completion.
- cu_rst_busy_i  in  1  computing-unit FIFO reset busy.
- mem_rd_en_o  out  1  scratchpad read strobe.
- mem_addr_o  out  ADDR_W  read address.
- mem_rdata_i  in  LANES*DATA_W  read data, valid the cycle after mem_rd_en_o; lane 0 in LSBs.
- weight_o  out  LANES*DATA_W  weight vector.
- weight_wr_en_o  out  1  weight write strobe.
- weight_full_i  in  1  weight FIFO full.
- weight_update_o  out  1  one-cycle weight-update request.
- offset_o  out  LANES*DATA_W  offset vector.
- offset_wr_en_o  out  1  offset write strobe.
- offset_full_i  in  1  offset FIFO full.
- activation_o  out  LANES*DATA_W  activation vector.
- activation_wr_en_o  out  1  activation write strobe.
- activation_full_i  in  1  activation FIFO full.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0, including strobes, addresses and data; skid buffer emptied; counters 0.
- Reset mid-job aborts the job immediately. No done pulse is issued.
- States:
  - IDLE: on start_i=1 and cu_rst_busy_i=0, latch the descriptor and go to FETCH_W. start_i while cu_rst_busy_i=1 is held off: remain in IDLE until the first cycle where both are 1/0 respectively.
  - FETCH_W: read LANES weight vectors at w_base_i + 0 .. LANES-1.
  - UPDATE: entered once all LANES weight writes have been accepted. Pulse weight_update_o for exactly one cycle, then go to FETCH_OFF.
  - FETCH_OFF: read one vector at off_base_i.
  - FETCH_ACT: read act_len_i vectors at act_base_i + k. Skipped when act_len_i = 0.
  - DONE: entered once the last write is accepted. Pulse done_o, then return to IDLE.
- busy_o = 1 in every state except IDLE. start_i while busy is ignored.
- Fetch pipeline:
  - 2-entry skid FIFO, with an in-flight counter for issued reads.
  - A read is issued only when (buffered + in-flight) < 2 and reads remain in the current phase.
  - Address increments per issued read; mem_addr_o is modulo 2^ADDR_W, wrapping to 0.
  - Read data is captured into the skid FIFO the cycle after mem_rd_en_o.
  - Reads for the next phase start only after the current phase's skid FIFO has drained, so vectors never cross destinations.
- Write handshake:
  - The target port's wr_en_o = skid FIFO not empty AND target full_i = 0, evaluated combinationally in the same cycle.
  - Data is the skid head; the head pops on wr_en_o.
  - While full_i = 1: wr_en_o = 0, data is held, and fetching stalls at 2 outstanding entries.
  - Only one of the three wr_en outputs is ever high in a given cycle.
  - Unselected data outputs hold their last value.
- Throughput: 1 vector/cycle with no backpressure. Start-to-first weight_wr_en latency = 3 cycles (latch, read, capture).
- Ordering guarantees:
  - weight_update_o asserts strictly after the LANES-th weight write.
  - The offset write precedes the first activation write.
- Simultaneous events: a full_i deassertion in the same cycle a read returns is legal. The buffer holds ≤ 2 entries by construction; no overflow is permitted, and the bench asserts on it.

Test Plan:
- Nominal (LANES=16, w_base=0x010, off_base=0x040, act_base=0x100, act_len=4, no backpressure) -> 16 weight writes on consecutive cycles starting 3 cycles after start, then one weight_update_o pulse, 1 offset write, 4 activation writes (addresses 0x100-0x103), done_o pulse; total 5 reads following the weights.
- Backpressure: hold weight_full_i=1 for 10 cycles after the 5th weight write -> no writes and at most 2 outstanding vectors; on release, weights 6..16 arrive in order with no loss or duplication.
- act_len_i=0 -> weights, update pulse and 1 offset write, then done_o; activation_wr_en_o never asserts.
- Address wrap (ADDR_W=12, act_base=0xFFE, act_len=4) -> reads at 0xFFE, 0xFFF, 0x000, 0x001.
- cu_rst_busy_i=1 when start_i pulses, held for 5 cycles -> busy_o stays 0 until cu_rst_busy_i drops, then the job runs normally.
- rst_i asserted during FETCH_ACT, asynchronously between clock edges -> all strobes 0 immediately, busy_o=0, no done_o; a subsequent job completes correctly.

Source files
------------

// File: rtl/cu_stream_loader_if.sv
// Bundle of the stream loader's job, scratchpad-read and FIFO-write signals.
// The loader is the master; the sequencer/scratchpad/FIFO side is the slave.
`ifndef DATA_TYPE_SIZE
`define DATA_TYPE_SIZE 16
`endif

interface cu_stream_loader_if #(
    parameter int LANES  = 16,
    parameter int DATA_W = `DATA_TYPE_SIZE,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
);
    logic                      start_i;
    logic [ADDR_W-1:0]         w_base_i;
    logic [ADDR_W-1:0]         off_base_i;
    logic [ADDR_W-1:0]         act_base_i;
    logic [LEN_W-1:0]          act_len_i;
    logic                      busy_o;
    logic                      done_o;
    logic                      cu_rst_busy_i;
    logic                      mem_rd_en_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic [LANES*DATA_W-1:0]   mem_rdata_i;
    logic [LANES*DATA_W-1:0]   weight_o;
    logic                      weight_wr_en_o;
    logic                      weight_full_i;
    logic                      weight_update_o;
    logic [LANES*DATA_W-1:0]   offset_o;
    logic                      offset_wr_en_o;
    logic                      offset_full_i;
    logic [LANES*DATA_W-1:0]   activation_o;
    logic                      activation_wr_en_o;
    logic                      activation_full_i;

    modport master (
        input  start_i, w_base_i, off_base_i, act_base_i, act_len_i, cu_rst_busy_i,
               mem_rdata_i, weight_full_i, offset_full_i, activation_full_i,
        output busy_o, done_o, mem_rd_en_o, mem_addr_o, weight_o, weight_wr_en_o,
               weight_update_o, offset_o, offset_wr_en_o, activation_o, activation_wr_en_o
    );

    modport slave (
        output start_i, w_base_i, off_base_i, act_base_i, act_len_i, cu_rst_busy_i,
               mem_rdata_i, weight_full_i, offset_full_i, activation_full_i,
        input  busy_o, done_o, mem_rd_en_o, mem_addr_o, weight_o, weight_wr_en_o,
               weight_update_o, offset_o, offset_wr_en_o, activation_o, activation_wr_en_o
    );
endinterface

// File: rtl/cu_stream_loader.sv
// Streams weights, a weight-update request, offsets and activations from the
// scratchpad into the computing unit's FIFOs through a 2-entry skid buffer.
`ifndef DATA_TYPE_SIZE
`define DATA_TYPE_SIZE 16
`endif

module cu_stream_loader #(
    parameter int LANES  = 16,
    parameter int DATA_W = `DATA_TYPE_SIZE,
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cu_stream_loader_if.master bus
);
    localparam int VEC_W = LANES * DATA_W;
    localparam int CNT_W = (LEN_W > $clog2(LANES + 1)) ? LEN_W : $clog2(LANES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_W, S_UPDATE, S_FETCH_OFF, S_FETCH_ACT, S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] off_base_q, off_base_d;
    logic [ADDR_W-1:0] act_base_q, act_base_d;
    logic [LEN_W-1:0]  act_len_q, act_len_d;
    logic [CNT_W-1:0]  rd_left_q, rd_left_d;
    logic [CNT_W-1:0]  wr_left_q, wr_left_d;
    logic [VEC_W-1:0]  buf0_q, buf0_d, buf1_q, buf1_d;
    logic [1:0]        count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [VEC_W-1:0]  weight_q, weight_d, offset_q, offset_d, act_q, act_d;

    logic       to_w, to_off, to_act, fetching;
    logic       target_full, wr_en, rd_en, last_wr;
    logic [2:0] occ_after_pop;

    // Target selection, write handshake and read issue.
    always_comb begin
        to_w          = (state_q == S_FETCH_W);
        to_off        = (state_q == S_FETCH_OFF);
        to_act        = (state_q == S_FETCH_ACT);
        fetching      = to_w | to_off | to_act;
        target_full   = (to_w & bus.weight_full_i) | (to_off & bus.offset_full_i)
                      | (to_act & bus.activation_full_i);
        wr_en         = fetching && (count_q != 2'd0) && !target_full;
        last_wr       = wr_en && (wr_left_q == CNT_W'(1));
        // Counting this cycle's pop keeps the pipe at one vector per cycle.
        occ_after_pop = 3'(count_q) + 3'(inflight_q) - 3'(wr_en);
        rd_en         = fetching && (rd_left_q != '0) && (occ_after_pop < 3'd2);
    end

    // Skid buffer: entry 0 is the head.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        buf0_d     = buf0_q;
        buf1_d     = buf1_q;
        count_d    = count_q;
        inflight_d = rd_en;
        if (inflight_q && wr_en) begin
            if (count_q == 2'd2) begin
                buf0_d = buf1_q;
                buf1_d = bus.mem_rdata_i;
            end else begin
                buf0_d = bus.mem_rdata_i;
            end
        end else if (wr_en) begin
            buf0_d  = buf1_q;
            count_d = count_q - 2'd1;
        end else if (inflight_q) begin
            if (count_q == 2'd0) buf0_d = bus.mem_rdata_i;
            else                 buf1_d = bus.mem_rdata_i;
            count_d = count_q + 2'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = rd_en ? addr_q + ADDR_W'(1) : addr_q;
        rd_left_d  = rd_en ? rd_left_q - CNT_W'(1) : rd_left_q;
        wr_left_d  = wr_en ? wr_left_q - CNT_W'(1) : wr_left_q;
        off_base_d = off_base_q;
        act_base_d = act_base_q;
        act_len_d  = act_len_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i && !bus.cu_rst_busy_i) begin
                    off_base_d = bus.off_base_i;
                    act_base_d = bus.act_base_i;
                    act_len_d  = bus.act_len_i;
                    addr_d     = bus.w_base_i;
                    rd_left_d  = CNT_W'(LANES);
                    wr_left_d  = CNT_W'(LANES);
                    state_d    = S_FETCH_W;
                end
            end
            S_FETCH_W: if (last_wr) state_d = S_UPDATE;
            S_UPDATE: begin
                addr_d    = off_base_q;
                rd_left_d = CNT_W'(1);
                wr_left_d = CNT_W'(1);
                state_d   = S_FETCH_OFF;
            end
            S_FETCH_OFF: begin
                if (last_wr) begin
                    if (act_len_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d    = act_base_q;
                        rd_left_d = CNT_W'(act_len_q);
                        wr_left_d = CNT_W'(act_len_q);
                        state_d   = S_FETCH_ACT;
                    end
                end
            end
            S_FETCH_ACT: if (last_wr) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // A port shows the skid head while it is the target; otherwise it holds its last value.
    always_comb begin
        weight_d = (to_w   && count_q != 2'd0) ? buf0_q : weight_q;
        offset_d = (to_off && count_q != 2'd0) ? buf0_q : offset_q;
        act_d    = (to_act && count_q != 2'd0) ? buf0_q : act_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
        if (rst_i) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            off_base_q <= '0;
            act_base_q <= '0;
            act_len_q  <= '0;
            rd_left_q  <= '0;
            wr_left_q  <= '0;
            // NOTE: the skid entries are reset too, so the data ports read 0 after reset.
            buf0_q     <= '0;
            buf1_q     <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            weight_q   <= '0;
            offset_q   <= '0;
            act_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            off_base_q <= off_base_d;
            act_base_q <= act_base_d;
            act_len_q  <= act_len_d;
            rd_left_q  <= rd_left_d;
            wr_left_q  <= wr_left_d;
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            weight_q   <= weight_d;
            offset_q   <= offset_d;
            act_q      <= act_d;
        end
    end

    assign bus.busy_o             = (state_q != S_IDLE);
    assign bus.done_o             = (state_q == S_DONE);
    assign bus.weight_update_o    = (state_q == S_UPDATE);
    assign bus.mem_rd_en_o        = rd_en;
    assign bus.mem_addr_o         = addr_q;
    assign bus.weight_wr_en_o     = wr_en & to_w;
    assign bus.offset_wr_en_o     = wr_en & to_off;
    assign bus.activation_wr_en_o = wr_en & to_act;
    assign bus.weight_o           = weight_d;
    assign bus.offset_o           = offset_d;
    assign bus.activation_o       = act_d;
endmodule
